alu_scheduler: RTL and testbench
================================

// Module: alu_scheduler
// PURPOSE
//  Shares one combinational 8-bit ALU (8 ops, NZVC flags) among N_REQ requesters with fair round-robin arbitration.
//  Sits between the requesters (control unit, address generator, debug port) and the ALU instance.
//  Runs a 3-state sequencer: arbitrate, execute, respond.
//  Keeps a condition-code register holding the flags of the last completed operation, for branch logic.
// PARAMETERS
//  N_REQ  4  number of requesters; legal range 2..8; the pointer width is $clog2(N_REQ)
// PORTS
//  clock       in   1        single clock; all logic on posedge
//  reset       in   1        synchronous, active-high
//  req_valid   in   N_REQ    requester i has an operation pending
//  req_a       in   8*N_REQ  operand A; slice [8i+7:8i] belongs to requester i
//  req_b       in   8*N_REQ  operand B, same slicing
//  req_sel     in   3*N_REQ  ALU op select for requester i, slice [3i+2:3i]
//  req_ready   out  N_REQ    one-hot, 1-cycle grant; operands were captured this cycle
//  alu_a       out  8        to ALU operand A (registered)
//  alu_b       out  8        to ALU operand B (registered)
//  alu_sel     out  3        to ALU op select (registered)
//  alu_result  in   8        from ALU Result (combinational)
//  alu_nzvc    in   4        from ALU flags {N,Z,V,C}
//  rsp_valid   out  N_REQ    one-hot; response for requester i is valid
//  rsp_result  out  8        registered result
//  rsp_nzvc    out  4        registered flags
//  rsp_ready   in   1        consumer accepts the response
//  ccr         out  4        flags of the last accepted response
//  busy        out  1        state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, rr_ptr=0, operand registers 0, grant_id=0.
//    Reset overrides everything, including mid-operation; a pending response is dropped, not delivered.
//  IDLE:
//    - If any req_valid bit is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
//    - Capture that requester's a/b/sel into alu_a/alu_b/alu_sel and record grant_id.
//    - Pulse req_ready[grant_id] for this cycle only.
//    - Set rr_ptr = (grant_id+1) mod N_REQ; go to EXEC.
//    - If no bit is set: stay in IDLE; rr_ptr and the operand registers are unchanged.
//  EXEC:
//    - Register alu_result and alu_nzvc into rsp_result and rsp_nzvc.
//    - Set rsp_valid[grant_id]; go to RESP.
//  RESP:
//    - rsp_valid, rsp_result and rsp_nzvc stay stable until rsp_ready=1.
//    - On the rsp_ready cycle: ccr <= rsp_nzvc, rsp_valid <= 0, go to IDLE.
//    - rsp_ready sampled outside RESP is ignored.
//  Latency: grant at cycle t, rsp_valid high from t+2. Minimum 3 cycles per op, i.e. throughput 1 op / 3 cycles.
//  req_valid may drop at any time; requesters are sampled only in IDLE.
//    A requester whose valid drops before grant simply loses its turn.
//  req_ready and req_valid are not combinationally looped; req_ready depends only on state and the IDLE arbitration.
//  A requester may re-request while its own response is pending.
//    It is considered again only after the return to IDLE, behind the round-robin pointer.
//  Flags are passed through exactly as the ALU produces them; no masking or recomputation.
//  alu_a/b/sel hold their values outside EXEC, so the ALU output stays stable.
//  Invalid sel values do not exist (3-bit, all 8 ops defined).
//  Default case in the FSM returns to IDLE.
// TESTING
//  T1 req0: A=8'h7F, B=8'h01, sel=000 (ADD) -> req_ready[0] at t, rsp_valid=0001 at t+2, result 8'h80, nzvc 4'b1010.
//  T2 req1: A=8'h05, B=8'h05, sel=010 (SUB) -> result 8'h00, nzvc 4'b0100; ccr=4'b0100 after rsp_ready.
//  T3 req2: A=8'hFF, sel=001 (INC) -> result 8'h00, nzvc 4'b0101.
//  T4 Post-reset, req0 and req2 held continuously -> grants in order 0,2,0,2.
//    With all 4 held: 0,1,2,3,0; no requester is granted twice in a row while others wait.
//  T5 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, no new req_ready, busy=1.
//    Then rsp_ready=1 -> IDLE next cycle.
//  T6 Assert reset during EXEC and during RESP -> next cycle all outputs 0, no response delivered, rr_ptr=0.
//    Then req3 alone is granted first.

Source files
------------

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational 8-bit ALU among N_REQ requesters.
// Sequencer: IDLE (arbitrate and capture operands) -> EXEC (register ALU output)
// -> RESP (hold the response until it is accepted, then latch flags into ccr).
module alu_scheduler #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  input  logic [3*N_REQ-1:0]   req_sel,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_sel,
  input  logic [7:0]           alu_result,
  input  logic [3:0]           alu_nzvc,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [7:0]           rsp_result,
  output logic [3:0]           rsp_nzvc,
  input  logic                 rsp_ready,
  output logic [3:0]           ccr,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned FW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_rr_ptr;
  logic [PW-1:0]      r_grant_id;
  logic [DW-1:0]      r_alu_a;
  logic [DW-1:0]      r_alu_b;
  logic [SW-1:0]      r_alu_sel;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [DW-1:0]      r_rsp_result;
  logic [FW-1:0]      r_rsp_nzvc;
  logic [FW-1:0]      r_ccr;

  logic               w_any;
  logic [PW-1:0]      w_gnt_id;
  logic [PW-1:0]      w_rr_nxt;
  logic [DW-1:0]      w_a;
  logic [DW-1:0]      w_b;
  logic [SW-1:0]      w_sel;
  logic [N_REQ-1:0]   w_ready;
  logic [N_REQ-1:0]   w_rsp_onehot;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned v_idx;
    w_any    = 1'b0;
    w_gnt_id = '0;
    v_idx    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      v_idx = (32'(r_rr_ptr) + k) % N_REQ;
      if (!w_any && req_valid[PW'(v_idx)]) begin
        w_any    = 1'b1;
        w_gnt_id = PW'(v_idx);
      end
    end
  end

  // Select the winning requester's operand slices and the pointer that follows it.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sel = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (PW'(j) == w_gnt_id) begin
        w_a   = req_a[DW*j +: DW];
        w_b   = req_b[DW*j +: DW];
        w_sel = req_sel[SW*j +: SW];
      end
    end
    w_rr_nxt = (32'(w_gnt_id) == N_REQ - 1) ? '0 : w_gnt_id + PW'(1);
    w_rsp_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant_id;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and the IDLE-cycle grant pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_ready[w_gnt_id] = 1'b1;
          w_state_nxt       = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, response registers and condition-code register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_nzvc   <= '0;
      r_ccr        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_alu_a    <= w_a;
            r_alu_b    <= w_b;
            r_alu_sel  <= w_sel;
            r_grant_id <= w_gnt_id;
            r_rr_ptr   <= w_rr_nxt;
          end
        end
        S_EXEC: begin
          r_rsp_result <= alu_result;
          r_rsp_nzvc   <= alu_nzvc;
          r_rsp_valid  <= w_rsp_onehot;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_ccr       <= r_rsp_nzvc;
            r_rsp_valid <= '0;
          end
        end
        default: r_rsp_valid <= '0;
      endcase
    end
  end

  // Grant is suppressed while reset is asserted so every output reads 0 during reset.
  assign req_ready  = reset ? '0 : w_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_nzvc   = r_rsp_nzvc;
  assign ccr        = r_ccr;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: behavioural ALU, reference sequencer model
// and a scoreboard of expected responses pushed at grant and popped at acceptance.
module tb_alu_scheduler;

  localparam int N = 4;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [3*N-1:0] req_sel;
  logic [N-1:0]   req_ready;
  logic [7:0]     alu_a;
  logic [7:0]     alu_b;
  logic [2:0]     alu_sel;
  logic [7:0]     alu_result;
  logic [3:0]     alu_nzvc;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_result;
  logic [3:0]     rsp_nzvc;
  logic           rsp_ready;
  logic [3:0]     ccr;
  logic           busy;

  logic [7:0] op_a   [N];
  logic [7:0] op_b   [N];
  logic [2:0] op_sel [N];

  alu_scheduler #(.N_REQ(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_nzvc   (alu_nzvc),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_nzvc   (rsp_nzvc),
    .rsp_ready  (rsp_ready),
    .ccr        (ccr),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU: 000 ADD, 001 INC, 010 SUB, 011 DEC, 100 AND, 101 OR, 110 XOR, 111 NOT A.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] s);
    logic [8:0] t;
    logic [7:0] r;
    logic       v;
    logic       c;
    logic [7:0] bb;
    v = 1'b0; c = 1'b0; r = 8'h00;
    bb = (s == 3'd1 || s == 3'd3) ? 8'h01 : b;
    case (s)
      3'd0, 3'd1: begin
        t = {1'b0, a} + {1'b0, bb};
        r = t[7:0]; c = t[8];
        v = (a[7] == bb[7]) && (r[7] != a[7]);
      end
      3'd2, 3'd3: begin
        r = a - bb; c = (a < bb);
        v = (a[7] != bb[7]) && (r[7] != a[7]);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = ~a;
    endcase
    return {r[7], (r == 8'h00), v, c, r};
  endfunction

  always_comb begin
    {alu_nzvc, alu_result} = alu_ref(alu_a, alu_b, alu_sel);
    for (int k = 0; k < N; k++) begin
      req_a[8*k +: 8]   = op_a[k];
      req_b[8*k +: 8]   = op_b[k];
      req_sel[3*k +: 3] = op_sel[k];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] res;
    logic [3:0] nzvc;
  } sb_t;

  sb_t sb[$];
  int  grant_log[$];
  int  cyc = 0;
  int  g_cyc = 0;

  localparam int M_IDLE = 0, M_EXEC = 1, M_RESP = 2;
  int         m_state = M_IDLE;
  int         m_rr    = 0;
  logic [3:0] m_ccr   = 4'h0;
  int         m_gid;
  int         m_j;
  logic       m_found;
  sb_t        m_e;

  always @(posedge clock) cyc++;

  // Reference sequencer: predicts grants, pushes expected responses, checks every cycle.
  always @(negedge clock) begin
    if (reset) begin
      check("rst_req_ready", 32'(req_ready), 32'h0);
      m_state = M_IDLE; m_rr = 0; m_ccr = 4'h0;
      sb.delete();
    end else begin
      check("ccr", 32'(ccr), 32'(m_ccr));
      case (m_state)
        M_IDLE: begin
          m_found = 1'b0; m_gid = 0;
          for (int k = 0; k < N; k++) begin
            m_j = (m_rr + k) % N;
            if (!m_found && req_valid[m_j]) begin m_found = 1'b1; m_gid = m_j; end
          end
          check("req_ready", 32'(req_ready), m_found ? (32'h1 << m_gid) : 32'h0);
          check("busy_idle", 32'(busy), 32'h0);
          if (m_found) begin
            m_e.id = m_gid; m_e.a = op_a[m_gid]; m_e.b = op_b[m_gid]; m_e.sel = op_sel[m_gid];
            {m_e.nzvc, m_e.res} = alu_ref(m_e.a, m_e.b, m_e.sel);
            sb.push_back(m_e);
            grant_log.push_back(m_gid);
            m_rr = (m_gid + 1) % N;
            m_state = M_EXEC;
          end
        end
        M_EXEC: begin
          check("exec_req_ready", 32'(req_ready), 32'h0);
          check("exec_rsp_valid", 32'(rsp_valid), 32'h0);
          check("exec_busy", 32'(busy), 32'h1);
          if (sb.size() > 0)
            check("exec_operands", {13'h0, alu_sel, alu_b, alu_a},
                  {13'h0, sb[$].sel, sb[$].b, sb[$].a});
          m_state = M_RESP;
        end
        default: begin
          if (sb.size() == 0) begin
            check("sb_nonempty", 32'h0, 32'h1);
            m_state = M_IDLE;
          end else begin
            check("rsp_valid", 32'(rsp_valid), 32'h1 << sb[0].id);
            check("rsp_result", 32'(rsp_result), 32'(sb[0].res));
            check("rsp_nzvc", 32'(rsp_nzvc), 32'(sb[0].nzvc));
            check("resp_req_ready", 32'(req_ready), 32'h0);
            check("resp_busy", 32'(busy), 32'h1);
            if (rsp_ready) begin
              m_ccr = sb[0].nzvc;
              void'(sb.pop_front());
              m_state = M_IDLE;
            end
          end
        end
      endcase
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] s);
    logic ok;
    op_a[id] = a; op_b[id] = b; op_sel[id] = s;
    req_valid[id] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (req_ready[id]) begin ok = 1'b1; g_cyc = cyc; break; end
    end
    check("grant_seen", 32'(ok), 32'h1);
    @(posedge clock); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic expect_rsp(input int id, input logic [7:0] res, input logic [3:0] nzvc);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (rsp_valid != '0) begin ok = 1'b1; break; end
    end
    check("rsp_seen", 32'(ok), 32'h1);
    check("rsp_latency", 32'(cyc - g_cyc), 32'd2);
    check("k_rsp_valid", 32'(rsp_valid), 32'h1 << id);
    check("k_rsp_result", 32'(rsp_result), 32'(res));
    check("k_rsp_nzvc", 32'(rsp_nzvc), 32'(nzvc));
    @(negedge clock);
    check("k_ccr", 32'(ccr), 32'(nzvc));
    check("k_idle_busy", 32'(busy), 32'h0);
    @(posedge clock); #1;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (!busy && sb.size() == 0) begin ok = 1'b1; break; end
    end
    check("drain", 32'(ok), 32'h1);
    @(posedge clock); #1;
  endtask

  int         exp_a[4] = '{0, 2, 0, 2};
  int         exp_b[5] = '{0, 1, 2, 3, 0};
  logic [7:0] hold_res;
  logic [3:0] hold_nzvc;
  logic       seen;

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < N; k++) begin op_a[k] = 8'h00; op_b[k] = 8'h00; op_sel[k] = 3'd0; end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_outputs", {12'h0, rsp_valid, rsp_nzvc, rsp_result},  32'h0);
    check("rst_alu", {13'h0, alu_sel, alu_b, alu_a}, 32'h0);
    check("rst_ccr_busy", {27'h0, busy, ccr}, 32'h0);
    @(posedge clock); #1;

    // T1..T3 directed operations
    issue(0, 8'h7F, 8'h01, 3'b000); expect_rsp(0, 8'h80, 4'b1010);
    issue(1, 8'h05, 8'h05, 3'b010); expect_rsp(1, 8'h00, 4'b0100);
    issue(2, 8'hFF, 8'h00, 3'b001); expect_rsp(2, 8'h00, 4'b0101);

    // T4 fairness with continuous requests
    do_reset(2);
    grant_log.delete();
    req_valid = 4'b0101;
    repeat (15) @(posedge clock); #1;
    req_valid = '0;
    drain();
    check("t4a_count", 32'(grant_log.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) check("t4a_order", 32'(grant_log[i]), 32'(exp_a[i]));
    do_reset(2);
    grant_log.delete();
    req_valid = 4'b1111;
    repeat (15) @(posedge clock); #1;
    req_valid = '0;
    drain();
    check("t4b_count", 32'(grant_log.size() >= 5), 32'h1);
    for (int i = 0; i < 5; i++) check("t4b_order", 32'(grant_log[i]), 32'(exp_b[i]));

    // T5 backpressure: response held, no new grant while another requester waits
    rsp_ready = 1'b0;
    issue(3, 8'h3C, 8'hA5, 3'b010);
    op_a[1] = 8'h11; op_b[1] = 8'h22; op_sel[1] = 3'b101;
    req_valid[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (rsp_valid != '0) begin seen = 1'b1; break; end
    end
    check("t5_rsp_seen", 32'(seen), 32'h1);
    hold_res = rsp_result; hold_nzvc = rsp_nzvc;
    check("t5_rsp_value", {20'h0, hold_nzvc, hold_res}, 32'hB97);
    repeat (10) @(negedge clock);
    check("t5_stable", {20'h0, rsp_nzvc, rsp_result}, {20'h0, hold_nzvc, hold_res});
    check("t5_valid", 32'(rsp_valid), 32'h8);
    check("t5_busy", 32'(busy), 32'h1);
    check("t5_no_grant", 32'(req_ready), 32'h0);
    @(posedge clock); #1 rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t5_idle", 32'(busy), 32'h0);
    check("t5_next_grant", 32'(req_ready), 32'h2);
    check("t5_ccr", 32'(ccr), 32'hB);
    @(posedge clock); #1 req_valid[1] = 1'b0;
    drain();

    // T6a reset during EXEC, after the pointer has moved past requester 2
    issue(2, 8'h40, 8'h40, 3'b000);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("t6a_rsp", {12'h0, rsp_valid, rsp_nzvc, rsp_result}, 32'h0);
    check("t6a_alu", {13'h0, alu_sel, alu_b, alu_a}, 32'h0);
    check("t6a_ccr_busy", {27'h0, busy, ccr}, 32'h0);
    @(posedge clock); #1 req_valid = 4'b1010;
    @(negedge clock);
    check("t6a_rr_reset", 32'(req_ready), 32'h2);
    @(posedge clock); #1 req_valid = '0;
    drain();

    // T6b reset during RESP drops the pending response
    rsp_ready = 1'b0;
    issue(0, 8'h01, 8'h02, 3'b000);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (rsp_valid != '0) begin seen = 1'b1; break; end
    end
    check("t6b_in_resp", 32'(seen), 32'h1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0; rsp_ready = 1'b1;
    @(negedge clock);
    check("t6b_rsp", {12'h0, rsp_valid, rsp_nzvc, rsp_result}, 32'h0);
    check("t6b_busy", 32'(busy), 32'h0);
    @(posedge clock); #1 req_valid = 4'b1000;
    @(negedge clock);
    check("t6b_req3_first", 32'(req_ready), 32'h8);
    @(posedge clock); #1 req_valid = '0;
    drain();

    // Random traffic with random backpressure; the reference model checks every cycle
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom);
      for (int k = 0; k < N; k++) begin
        op_a[k] = 8'($urandom); op_b[k] = 8'($urandom); op_sel[k] = 3'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    req_valid = '0; rsp_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
